// File: rtl/datapath_pkg.sv
// datapath_pkg: shared constants for the datapath (default width, FS codes, STATUS bit indices)
package datapath_pkg;
   localparam int WIDTH_DEF = 4;
   localparam logic [3:0] FS_TFRA  = 4'b0000;
   localparam logic [3:0] FS_INC   = 4'b0001;
   localparam logic [3:0] FS_ADD   = 4'b0010;
   localparam logic [3:0] FS_ADDC  = 4'b0011;
   localparam logic [3:0] FS_ADDNB = 4'b0100;
   localparam logic [3:0] FS_SUB   = 4'b0101;
   localparam logic [3:0] FS_DEC   = 4'b0110;
   localparam logic [3:0] FS_TFRA2 = 4'b0111;
   localparam logic [3:0] FS_AND   = 4'b1000;
   localparam logic [3:0] FS_OR    = 4'b1001;
   localparam logic [3:0] FS_XOR   = 4'b1010;
   localparam logic [3:0] FS_NOTA  = 4'b1011;
   localparam logic [3:0] FS_TFRB  = 4'b1100;
   localparam logic [3:0] FS_SHR   = 4'b1101;
   localparam logic [3:0] FS_SHL   = 4'b1110;
   localparam logic [3:0] FS_ZERO  = 4'b1111;
   localparam int FLAG_V = 3;
   localparam int FLAG_C = 2;
   localparam int FLAG_N = 1;
   localparam int FLAG_Z = 0;
endpackage

// File: rtl/datapath_unit_if.sv
// datapath_unit_if: control word in, buses and STATUS out
//   master (control unit): drives da/aa/ba/mb/md/rw/mw/fs/constant, reads a_bus/b_bus/d_bus/status
//   slave  (datapath):     the reverse
interface datapath_unit_if #(
   parameter int WIDTH = datapath_pkg::WIDTH_DEF,
   parameter int NREGS = 4
);
   localparam int AW = $clog2(NREGS);
   logic [AW-1:0]    da;
   logic [AW-1:0]    aa;
   logic [AW-1:0]    ba;
   logic             mb;
   logic             md;
   logic             rw;
   logic             mw;
   logic [3:0]       fs;
   logic [WIDTH-1:0] constant;
   logic [WIDTH-1:0] a_bus;
   logic [WIDTH-1:0] b_bus;
   logic [WIDTH-1:0] d_bus;
   logic [3:0]       status;
   modport master (output da, aa, ba, mb, md, rw, mw, fs, constant,
                   input  a_bus, b_bus, d_bus, status);
   modport slave  (input  da, aa, ba, mb, md, rw, mw, fs, constant,
                   output a_bus, b_bus, d_bus, status);
endinterface

// File: rtl/datapath_unit_register_file.sv
// register_file: NREGS x WIDTH registers, two combinational read ports, one synchronous write port
//   i_clk, i_rst_n (async active-low clear), i_we/i_wa/i_wd write port,
//   i_ra/o_a and i_rb/o_b read ports.
//   Build option R0_ZERO_EN: R0 reads as 0 and writes to it are dropped.
module register_file #(
   parameter int WIDTH = 4,
   parameter int NREGS = 4,
   localparam int AW = $clog2(NREGS)
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic             i_we,
   input  logic [AW-1:0]    i_wa,
   input  logic [WIDTH-1:0] i_wd,
   input  logic [AW-1:0]    i_ra,
   input  logic [AW-1:0]    i_rb,
   output logic [WIDTH-1:0] o_a,
   output logic [WIDTH-1:0] o_b
);
   logic [WIDTH-1:0] r_regs [NREGS];
   logic             w_we;
`ifdef R0_ZERO_EN
   assign w_we = i_we && (i_wa != '0);
   assign o_a  = (i_ra == '0) ? '0 : r_regs[i_ra];
   assign o_b  = (i_rb == '0) ? '0 : r_regs[i_rb];
`else
   assign w_we = i_we;
   assign o_a  = r_regs[i_ra];
   assign o_b  = r_regs[i_rb];
`endif
   always_ff @(posedge i_clk or negedge i_rst_n)
      if (!i_rst_n)
         for (int i = 0; i < NREGS; i++) r_regs[i] <= '0;
      else if (w_we)
         r_regs[i_wa] <= i_wd;
endmodule

// File: rtl/datapath_unit.sv
// datapath_unit: single-cycle datapath (register file, function unit, data memory, STATUS register)
//   i_clk   rising-edge clock
//   i_rst_n async active-low reset (registers and STATUS; memory keeps its contents)
//   io      slave side of datapath_unit_if: control word in, A/B/D buses and STATUS {V,C,N,Z} out
//   Build option R0_ZERO_EN: forwarded to register_file, hard-wires R0 to 0.
module datapath_unit
   import datapath_pkg::*;
#(
   parameter int WIDTH      = WIDTH_DEF,
   parameter int NREGS      = 4,
   parameter int DMEM_DEPTH = 16
) (
   input  logic  i_clk,
   input  logic  i_rst_n,
   datapath_unit_if.slave io
);
   localparam int MAW = $clog2(DMEM_DEPTH);
   logic [WIDTH-1:0] r_mem [DMEM_DEPTH];
   logic [3:0]       r_status;
   logic [WIDTH-1:0] w_a;
   logic [WIDTH-1:0] w_rb;
   logic [WIDTH-1:0] w_b;
   logic [WIDTH-1:0] w_y;
   logic             w_cin;
   logic [WIDTH:0]   w_sum;
   logic [WIDTH-1:0] w_f;
   logic [WIDTH-1:0] w_d;
   logic [WIDTH-1:0] w_mrd;
   logic             w_arith;
   register_file #(.WIDTH(WIDTH), .NREGS(NREGS)) u_rf (
      .i_clk  (i_clk),
      .i_rst_n(i_rst_n),
      .i_we   (io.rw),
      .i_wa   (io.da),
      .i_wd   (w_d),
      .i_ra   (io.aa),
      .i_rb   (io.ba),
      .o_a    (w_a),
      .o_b    (w_rb)
   );
   assign w_b     = io.mb ? io.constant : w_rb;
   assign w_mrd   = r_mem[w_a[MAW-1:0]];
   assign w_arith = !io.fs[3];
   // Every arithmetic code is A + y + cin through one adder; A-B is A+~B+1, A-1 is A+all-ones.
   always_comb begin
      w_y   = '0;
      w_cin = 1'b0;
      case (io.fs)
         FS_INC:   w_cin = 1'b1;
         FS_ADD:   w_y = w_b;
         FS_ADDC:  begin w_y = w_b; w_cin = 1'b1; end
         FS_ADDNB: w_y = ~w_b;
         FS_SUB:   begin w_y = ~w_b; w_cin = 1'b1; end
         FS_DEC:   w_y = '1;
         default:  ;
      endcase
      w_sum = {1'b0, w_a} + {1'b0, w_y} + {{WIDTH{1'b0}}, w_cin};
      case (io.fs)
         FS_AND:  w_f = w_a & w_b;
         FS_OR:   w_f = w_a | w_b;
         FS_XOR:  w_f = w_a ^ w_b;
         FS_NOTA: w_f = ~w_a;
         FS_TFRB: w_f = w_b;
         FS_SHR:  w_f = w_b >> 1;
         FS_SHL:  w_f = w_b << 1;
         FS_ZERO: w_f = '0;
         default: w_f = w_sum[WIDTH-1:0];
      endcase
   end
   assign w_d = io.md ? w_mrd : w_f;
   // Memory has no reset; the i_rst_n term drops a write on an edge that lands during reset.
   always_ff @(posedge i_clk)
      if (io.mw && i_rst_n) r_mem[w_a[MAW-1:0]] <= w_b;
   always_ff @(posedge i_clk or negedge i_rst_n)
      if (!i_rst_n)
         r_status <= '0;
      else begin
         r_status[FLAG_Z] <= (w_f == '0);
         r_status[FLAG_N] <= w_f[WIDTH-1];
         r_status[FLAG_C] <= w_arith && w_sum[WIDTH];
         r_status[FLAG_V] <= w_arith && (w_a[WIDTH-1] == w_y[WIDTH-1]) && (w_sum[WIDTH-1] != w_a[WIDTH-1]);
      end
   assign io.a_bus  = w_a;
   assign io.b_bus  = w_b;
   assign io.d_bus  = w_d;
   assign io.status = r_status;
endmodule
